// File: rtl/irq_controller_if.sv
// CPU register-bus bundle for irq_controller: a write port plus a read port
// whose data comes back one cycle after the address.
interface irq_controller_if;
   logic [15:0] waddr;
   logic [15:0] wdata;
   logic        wenable;
   logic [15:0] raddr;
   logic [15:0] rdata;

   modport master (output waddr, output wdata, output wenable, output raddr, input rdata);
   modport slave  (input waddr, input wdata, input wenable, input raddr, output rdata);
endinterface

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with a 4-word register window: fixed lowest-index
// priority, one interrupt in flight at a time, released by an EOI write.
module irq_controller #(
   parameter int unsigned N_SRC     = 4,
   parameter logic [15:0] BASE_ADDR = 16'hFF10,
   parameter logic [15:0] VEC_BASE  = 16'h0100
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_SRC-1:0] src_irq,
   irq_controller_if.slave  bus,
   output logic             irq,
   input  logic             reset_irq,
   output logic [15:0]      irq_vector,
   output logic [3:0]       irq_id
);

   localparam logic [15:0] A_MASK = BASE_ADDR;
   localparam logic [15:0] A_PEND = BASE_ADDR + 16'd1;
   localparam logic [15:0] A_STAT = BASE_ADDR + 16'd2;
   localparam logic [15:0] A_EOI  = BASE_ADDR + 16'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_SERVICE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic [N_SRC-1:0]   pending_q, pending_d;
   logic [N_SRC-1:0]   src_q, src_d;
   logic               irq_q, irq_d;
   logic [3:0]         irq_id_q, irq_id_d;
   logic [15:0]        irq_vector_q, irq_vector_d;
   logic               in_service_q, in_service_d;
   logic [15:0]        rdata_q, rdata_d;

   logic [N_SRC-1:0]   rise_c;
   logic [N_SRC-1:0]   active_c;
   logic [N_SRC-1:0]   clr_c;
   logic [3:0]         lowest_c;
   logic               found_c;
   logic               wr_mask_c, wr_pend_c, wr_eoi_c;
   logic               unused_wdata_c;

   assign unused_wdata_c = ^bus.wdata;

   // State register; edge history tracks the lines even in reset so held lines stay quiet
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         mask_q       <= '0;
         pending_q    <= '0;
         src_q        <= src_d;
         irq_q        <= 1'b0;
         irq_id_q     <= '0;
         irq_vector_q <= VEC_BASE;
         in_service_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         pending_q    <= pending_d;
         src_q        <= src_d;
         irq_q        <= irq_d;
         irq_id_q     <= irq_id_d;
         irq_vector_q <= irq_vector_d;
         in_service_q <= in_service_d;
         rdata_q      <= rdata_d;
      end
   end

   // Register writes, arbitration FSM and read mux
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      pending_d    = pending_q;
      src_d        = src_irq;
      irq_d        = irq_q;
      irq_id_d     = irq_id_q;
      in_service_d = in_service_q;
      rdata_d      = '0;
      clr_c        = '0;
      lowest_c     = '0;
      found_c      = 1'b0;

      rise_c    = src_irq & ~src_q;
      active_c  = pending_q & mask_q;
      wr_mask_c = bus.wenable && (bus.waddr == A_MASK);
      wr_pend_c = bus.wenable && (bus.waddr == A_PEND);
      wr_eoi_c  = bus.wenable && (bus.waddr == A_EOI);

      for (int i = 0; i < N_SRC; i++) begin
         if (active_c[i] && !found_c) begin
            found_c  = 1'b1;
            lowest_c = 4'(i);
         end
      end

      if (wr_mask_c) mask_d = bus.wdata[N_SRC-1:0];
      if (wr_pend_c) clr_c  = bus.wdata[N_SRC-1:0];

      case (state_q)
         S_IDLE: begin
            if (found_c) begin
               irq_id_d = lowest_c;
               irq_d    = 1'b1;
               state_d  = S_ASSERT;
            end
         end
         S_ASSERT: begin
            if (reset_irq) begin
               for (int i = 0; i < N_SRC; i++) begin
                  if (irq_id_q == 4'(i)) clr_c[i] = 1'b1;
               end
               irq_d        = 1'b0;
               in_service_d = 1'b1;
               state_d      = S_SERVICE;
            end
         end
         S_SERVICE: begin
            if (wr_eoi_c) begin
               in_service_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A fresh edge always beats a clear of the same bit
      pending_d = (pending_q & ~clr_c) | rise_c;

      case (bus.raddr)
         A_MASK:  rdata_d = 16'(mask_q);
         A_PEND:  rdata_d = 16'(pending_q);
         A_STAT:  rdata_d = {6'b0, irq_q, in_service_q, 4'b0, irq_id_q};
         default: rdata_d = '0;
      endcase
   end

   assign irq_vector_d = VEC_BASE + 16'({irq_id_d, 4'b0000});

   assign irq        = irq_q;
   assign irq_id     = irq_id_q;
   assign irq_vector = irq_vector_q;
   assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register-access vector table, directed corner-case
// sequences, then randomized traffic against a behavioural model.
module tb_irq_controller;

   localparam logic [15:0] BASE   = 16'hFF10;
   localparam logic [15:0] VEC    = 16'h0100;
   localparam logic [15:0] A_MASK = BASE;
   localparam logic [15:0] A_PEND = BASE + 16'd1;
   localparam logic [15:0] A_STAT = BASE + 16'd2;
   localparam logic [15:0] A_EOI  = BASE + 16'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        reset_irq = 1'b0;
   logic [3:0]  src_irq = 4'b0;
   logic        irq;
   logic [15:0] irq_vector;
   logic [3:0]  irq_id;

   irq_controller_if bus();

   irq_controller #(.N_SRC(4), .BASE_ADDR(BASE), .VEC_BASE(VEC)) dut (
      .clock      (clock),
      .reset      (reset),
      .src_irq    (src_irq),
      .bus        (bus),
      .irq        (irq),
      .reset_irq  (reset_irq),
      .irq_vector (irq_vector),
      .irq_id     (irq_id)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          is_wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[14];

   // Behavioural model of the controller, kept as plain variables
   logic [3:0]  m_pend, m_mask, m_prev;
   int          m_phase;   // 0 idle, 1 waiting for acknowledge, 2 in service
   int          m_id;
   logic        m_irq, m_insvc;
   logic [15:0] m_rdata;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data);
      bus.waddr   = addr;
      bus.wdata   = data;
      bus.wenable = 1'b1;
      tick();
      bus.wenable = 1'b0;
   endtask

   task automatic rd(input logic [15:0] addr, output logic [15:0] data);
      bus.raddr = addr;
      tick();
      data = bus.rdata;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic pulse_ack();
      reset_irq = 1'b1;
      tick();
      reset_irq = 1'b0;
   endtask

   task automatic check_irq(input string name, input logic e_irq, input int e_id);
      chk({name, "_irq"}, 16'(irq), 16'(e_irq));
      chk({name, "_id"},  16'(irq_id), 16'(e_id));
      chk({name, "_vec"}, irq_vector, VEC + 16'(e_id) * 16'd16);
   endtask

   // One clock edge of the model, using the inputs currently driven
   task automatic model_edge();
      logic [3:0] act, nxt;
      int         lo;
      if (!reset) begin
         m_pend = '0; m_mask = '0; m_phase = 0; m_id = 0;
         m_irq = 1'b0; m_insvc = 1'b0; m_rdata = '0; m_prev = src_irq;
      end else begin
         case (bus.raddr)
            A_MASK:  m_rdata = 16'(m_mask);
            A_PEND:  m_rdata = 16'(m_pend);
            A_STAT:  m_rdata = {6'b0, m_irq, m_insvc, 4'b0, 4'(m_id)};
            default: m_rdata = '0;
         endcase
         nxt = m_pend;
         if (bus.wenable && bus.waddr == A_PEND) nxt = nxt & ~bus.wdata[3:0];
         act = m_pend & m_mask;
         lo = -1;
         for (int i = 3; i >= 0; i--) if (act[i]) lo = i;
         if (m_phase == 0 && lo >= 0) begin
            m_id = lo; m_irq = 1'b1; m_phase = 1;
         end else if (m_phase == 1 && reset_irq) begin
            nxt[m_id] = 1'b0; m_irq = 1'b0; m_insvc = 1'b1; m_phase = 2;
         end else if (m_phase == 2 && bus.wenable && bus.waddr == A_EOI) begin
            m_insvc = 1'b0; m_phase = 0;
         end
         m_pend = nxt | (src_irq & ~m_prev);
         if (bus.wenable && bus.waddr == A_MASK) m_mask = bus.wdata[3:0];
         m_prev = src_irq;
      end
   endtask

   initial begin
      logic [15:0] v;
      bus.waddr = '0; bus.wdata = '0; bus.wenable = 1'b0; bus.raddr = '0;

      // Reset state
      reset = 1'b0;
      bus.raddr = A_MASK;
      tick(); tick();
      check_irq("rst", 1'b0, 0);
      chk("rst_rdata", bus.rdata, 16'h0000);
      reset = 1'b1;

      // Register access table
      tbl[0]  = '{1'b0, A_MASK, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b0, A_PEND, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b0, A_STAT, 16'h0000, 16'h0000};
      tbl[3]  = '{1'b1, A_MASK, 16'hFFFF, 16'h0000};
      tbl[4]  = '{1'b0, A_MASK, 16'h0000, 16'h000F};
      tbl[5]  = '{1'b0, BASE + 16'd4, 16'h0000, 16'h0000};
      tbl[6]  = '{1'b0, 16'hFF0F, 16'h0000, 16'h0000};
      tbl[7]  = '{1'b1, A_MASK, 16'h0005, 16'h0000};
      tbl[8]  = '{1'b0, A_MASK, 16'h0000, 16'h0005};
      tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
      tbl[10] = '{1'b1, A_PEND, 16'hFFFF, 16'h0000};
      tbl[11] = '{1'b0, A_PEND, 16'h0000, 16'h0000};
      tbl[12] = '{1'b1, A_MASK, 16'h0000, 16'h0000};
      tbl[13] = '{1'b0, A_MASK, 16'h0000, 16'h0000};
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
         else begin
            rd(tbl[i].addr, v);
            chk($sformatf("vec%0d", i), v, tbl[i].exp);
         end
      end

      // Single source: assert two cycles after the pulse, acknowledge clears pending
      do_reset();
      wr(A_MASK, 16'h0003);
      src_irq = 4'b0010; tick(); src_irq = 4'b0000;
      chk("s1_early", 16'(irq), 16'h0000);
      tick();
      check_irq("s1_assert", 1'b1, 1);
      pulse_ack();
      chk("s1_ack_irq", 16'(irq), 16'h0000);
      rd(A_PEND, v); chk("s1_pend", v, 16'h0000);
      rd(A_STAT, v); chk("s1_stat", v, 16'h0101);
      wr(A_EOI, 16'h0000);
      rd(A_STAT, v); chk("s1_eoi", v & 16'h0300, 16'h0000);

      // Priority, EOI ignored in ASSERT, EOI coinciding with a new edge
      do_reset();
      wr(A_MASK, 16'h0005);
      src_irq = 4'b0101; tick(); src_irq = 4'b0000; tick();
      check_irq("s2_first", 1'b1, 0);
      wr(A_EOI, 16'h0000);
      check_irq("s2_eoi_ign", 1'b1, 0);
      rd(A_PEND, v); chk("s2_pend", v, 16'h0005);
      pulse_ack();
      chk("s2_ack", 16'(irq), 16'h0000);
      wr(A_EOI, 16'h1234);
      chk("s2_after_eoi", 16'(irq), 16'h0000);
      tick();
      check_irq("s2_second", 1'b1, 2);
      pulse_ack();
      src_irq = 4'b0001;
      wr(A_EOI, 16'h0000);
      src_irq = 4'b0000;
      chk("s2_eoi_edge", 16'(irq), 16'h0000);
      tick();
      check_irq("s2_third", 1'b1, 0);

      // Masked pending, late unmask, W1C racing a new edge
      do_reset();
      src_irq = 4'b1000; tick(); src_irq = 4'b0000; tick();
      rd(A_PEND, v); chk("s3_pend", v, 16'h0008);
      chk("s3_masked", 16'(irq), 16'h0000);
      wr(A_MASK, 16'h0008);
      tick();
      check_irq("s3_unmask", 1'b1, 3);
      src_irq = 4'b1000;
      wr(A_PEND, 16'h0008);
      src_irq = 4'b0000;
      rd(A_PEND, v); chk("s3_w1c_race", v, 16'h0008);
      check_irq("s3_hold", 1'b1, 3);

      // Line high through reset release creates no pending bit
      src_irq = 4'b0001;
      do_reset();
      wr(A_MASK, 16'h0001);
      repeat (100) tick();
      rd(A_PEND, v); chk("s4_held", v, 16'h0000);
      chk("s4_irq", 16'(irq), 16'h0000);
      src_irq = 4'b0000; tick();
      src_irq = 4'b0001; tick();
      rd(A_PEND, v); chk("s4_edge", v, 16'h0001);
      check_irq("s4_assert", 1'b1, 0);
      src_irq = 4'b0000;

      // Reset in SERVICE abandons the interrupt
      do_reset();
      wr(A_MASK, 16'h0002);
      src_irq = 4'b0010; tick(); src_irq = 4'b0000; tick();
      pulse_ack();
      rd(A_STAT, v); chk("s5_insvc", v, 16'h0101);
      reset = 1'b0; bus.raddr = A_STAT; tick();
      chk("s5_rst_rdata", bus.rdata, 16'h0000);
      reset = 1'b1; tick();
      chk("s5_stat", bus.rdata, 16'h0000);
      wr(A_MASK, 16'h0002);
      src_irq = 4'b0010; tick(); src_irq = 4'b0000; tick();
      check_irq("s5_new", 1'b1, 1);

      // Acknowledge in IDLE has no effect
      do_reset();
      pulse_ack();
      rd(A_STAT, v); chk("s6_stat", v, 16'h0000);
      chk("s6_irq", 16'(irq), 16'h0000);

      // Randomized traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset       = (cyc == 0 || $urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 3) == 0) src_irq = 4'($urandom);
         reset_irq   = ($urandom_range(0, 4) == 0);
         bus.wenable = ($urandom_range(0, 3) == 0);
         bus.waddr   = BASE + 16'($urandom_range(0, 4));
         bus.wdata   = 16'($urandom);
         bus.raddr   = BASE + 16'($urandom_range(0, 4));
         model_edge();
         tick();
         chk("rnd_irq", 16'(irq), 16'(m_irq));
         chk("rnd_id", 16'(irq_id), 16'(m_id));
         chk("rnd_vec", irq_vector, VEC + 16'(m_id) * 16'd16);
         chk("rnd_rdata", bus.rdata, m_rdata);
      end
      reset = 1'b1; reset_irq = 1'b0; bus.wenable = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
